fpga_top: RTL and testbench
===========================

# fpga_top

Board-level top of the video project: one 50 MHz system clock, switch-to-LED status logic, two 1 Hz heartbeat LEDs and a VGA timing and test-pattern generator. The VGA signals are driven through the `vga_if` interface (modport `vga_ifm`). The block sits directly under the board pin wrapper. It contains no external memory path.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `HDISP`, 800: visible pixels per line.
- `VDISP`, 480: visible lines per frame.
- `HFP` / `HPULSE` / `HBP`, 40 / 48 / 40: horizontal front porch, sync width and back porch, in pixels.
- `VFP` / `VPULSE` / `VBP`, 13 / 3 / 29: vertical front porch, sync width and back porch, in lines.
- `fpga_CLK`, input, 1: system clock. It is the only clock, and all logic is on its rising edge.
- `fpga_RST`, input, 1: reset, synchronous and active-high.
- `fpga_SW0`, input, 1: switch mirrored on LEDR0.
- `fpga_SW1`, input, 1: auxiliary-clock select request.
- `fpga_LEDR0`, output, 1: equals `fpga_SW0`.
- `fpga_LEDR1`, output, 1: 1 Hz heartbeat, counted in system clocks.
- `fpga_LEDR2`, output, 1: 1 Hz heartbeat, counted in pixel-enable ticks.
- `fpga_LEDR3`, output, 1: out-of-reset indicator.
- `fpga_SEL_CLK_AUX`, output, 1: equals `fpga_SW1`. It goes to the external clock-select pin.
- `vga_ifm`, interface, `vga_if`: `VGA_CLK`, `VGA_HS`, `VGA_VS`, `VGA_BLANK`, `VGA_SYNC` and `VGA_R`/`VGA_G`/`VGA_B` (8 bits each), all outputs.

## Operation
- LEDR0 and SEL_CLK_AUX are combinational pass-throughs and are not affected by reset.
- LEDR3 is a register. It is cleared to 0 by reset and is 1 from the first clock edge after `fpga_RST` falls.
- **LEDR1 counter:** counts 0 to CLK_FREQ/2−1. The LED toggles on wrap, giving a 1 s period.
- **Pixel enable:**
  - `pix_en` toggles every clock, so the pixel rate is CLK_FREQ/2.
  - VGA_CLK is the `pix_en` register, driven out.
  - All pixel logic advances only when `pix_en` = 1.
- **LEDR2 counter:** counts pixel ticks 0 to CLK_FREQ/4−1 and toggles on wrap, giving a 1 s period.
- **Horizontal counter `x`:** counts 0 to HDISP+HFP+HPULSE+HBP−1, then wraps to 0 and increments `y`.
- **Vertical counter `y`:** counts 0 to VDISP+VFP+VPULSE+VBP−1, then wraps to 0.
- VGA_HS = 0 when `x` is in [HDISP+HFP, HDISP+HFP+HPULSE), else 1.
- VGA_VS = 0 when `y` is in [VDISP+VFP, VDISP+VFP+VPULSE), else 1.
- VGA_BLANK = 1 only when `x` < HDISP and `y` < VDISP. VGA_SYNC is constant 0.
- RGB comes from the pattern selected under Configuration and is forced to 0 whenever BLANK = 0.
- Counter widths are $clog2 of each total. Counters wrap with no overflow state.

## Timing
- Reset values:
  - LEDR1, LEDR2, LEDR3 = 0.
  - All counters = 0; `pix_en` = 0; VGA_CLK = 0.
  - HS = 1, VS = 1, BLANK = 0, RGB = 0.
- VGA outputs are registered. Each is valid one pixel tick after the `x`/`y` value it encodes, with a fixed 1-tick pipeline for all of them.
- Reset asserted mid-frame or mid-blink takes effect on the next clock edge. Everything restarts from `x` = `y` = 0.
- A line wrap and a frame wrap on the same tick are handled in one update, so `y` goes from its maximum to 0 as `x` goes to 0.

## Configuration
- Macro `TEST_PATTERN_EN`.
- **Defined:** visible pixels where (`x` mod 16 = 0) or (`y` mod 16 = 0) are white (255,255,255); all other visible pixels are black.
- **Undefined:** RGB is constant 0. Sync, blank and LED behaviour are unchanged.

## Test plan
- **Reset release.** Hold `fpga_RST` = 1 for 10 clocks, expecting LEDR3 = 0, HS = VS = 1 and BLANK = 0. Then deassert and expect LEDR3 = 1 at the next rising edge.
- **Switch pass-through.** Set SW0 = 1 then 0, expecting LEDR0 = 1 then 0 at the following edge. Set SW1 = 1 and expect SEL_CLK_AUX = 1.
- **Heartbeats.**
  - Set CLK_FREQ = 2_000 and measure the spacing between two LEDR1 rising edges: 2_000 clocks (40 µs).
  - LEDR2 measured the same way: 2_000 clocks.
- **Small-geometry timing.** Use HDISP = 160, VDISP = 90 and the default porches.
  - HS low for 48 pixel ticks every 288.
  - VS low for 3 lines every 135.
  - BLANK high for 160 ticks per visible line.
- **Pattern (`TEST_PATTERN_EN` defined).**
  - Pixels (0,0), (16,5) and (3,32) are white.
  - Pixel (3,5) is black.
  - RGB = 0 during blanking.
- **Pattern (`TEST_PATTERN_EN` undefined).** Run 3 frames: RGB is 0 throughout and the sync counts match the small-geometry scenario.

Source files
------------

// File: rtl/fpga_top_if.sv
// VGA output bundle for fpga_top: pixel clock, syncs, blank and 8-bit RGB.
interface vga_if;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK;
  logic       VGA_SYNC;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;

  modport vga_ifm (
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/fpga_top.sv
// Board top: switch/LED status, two 1 Hz heartbeats, VGA timing and grid test pattern.
// Define TEST_PATTERN_EN for the white 16-pixel grid; otherwise RGB stays 0.
module fpga_top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29
) (
  input  logic   fpga_CLK,
  input  logic   fpga_RST,
  input  logic   fpga_SW0,
  input  logic   fpga_SW1,
  output logic   fpga_LEDR0,
  output logic   fpga_LEDR1,
  output logic   fpga_LEDR2,
  output logic   fpga_LEDR3,
  output logic   fpga_SEL_CLK_AUX,
  vga_if.vga_ifm vga_ifm
);
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int XW     = $clog2(HTOTAL);
  localparam int YW     = $clog2(VTOTAL);
  localparam int C1_N   = CLK_FREQ / 2;
  localparam int C2_N   = CLK_FREQ / 4;
  localparam int C1W    = $clog2(C1_N);
  localparam int C2W    = $clog2(C2_N);

  localparam logic [XW-1:0]  X_LAST  = XW'(HTOTAL - 1);
  localparam logic [XW-1:0]  X_VIS   = XW'(HDISP);
  localparam logic [XW-1:0]  HS_LO   = XW'(HDISP + HFP);
  localparam logic [XW-1:0]  HS_HI   = XW'(HDISP + HFP + HPULSE);
  localparam logic [YW-1:0]  Y_LAST  = YW'(VTOTAL - 1);
  localparam logic [YW-1:0]  Y_VIS   = YW'(VDISP);
  localparam logic [YW-1:0]  VS_LO   = YW'(VDISP + VFP);
  localparam logic [YW-1:0]  VS_HI   = YW'(VDISP + VFP + VPULSE);
  localparam logic [C1W-1:0] C1_LAST = C1W'(C1_N - 1);
  localparam logic [C2W-1:0] C2_LAST = C2W'(C2_N - 1);

  logic [C1W-1:0] c1_q, c1_d;
  logic [C2W-1:0] c2_q, c2_d;
  logic           led1_q, led1_d, led2_q, led2_d, led3_q, led3_d;
  logic           pix_en_q, pix_en_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [7:0]     rgb_q, rgb_d;
  logic           visible, grid;

  assign visible = (x_q < X_VIS) && (y_q < Y_VIS);

`ifdef TEST_PATTERN_EN
  assign grid = (x_q[3:0] == 4'd0) || (y_q[3:0] == 4'd0);
`else
  assign grid = 1'b0;
`endif

  always_comb begin
    c1_d     = (c1_q == C1_LAST) ? '0 : c1_q + C1W'(1);
    led1_d   = led1_q ^ (c1_q == C1_LAST);
    led3_d   = 1'b1;
    pix_en_d = ~pix_en_q;
    c2_d     = c2_q;
    led2_d   = led2_q;
    x_d      = x_q;
    y_d      = y_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    rgb_d    = rgb_q;
    if (pix_en_q) begin
      c2_d   = (c2_q == C2_LAST) ? '0 : c2_q + C2W'(1);
      led2_d = led2_q ^ (c2_q == C2_LAST);
      x_d    = (x_q == X_LAST) ? '0 : x_q + XW'(1);
      if (x_q == X_LAST)
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      // Outputs encode the current x/y, so they lag the counters by one tick.
      hs_d    = !((x_q >= HS_LO) && (x_q < HS_HI));
      vs_d    = !((y_q >= VS_LO) && (y_q < VS_HI));
      blank_d = visible;
      rgb_d   = (visible && grid) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge fpga_CLK) begin
    if (fpga_RST) begin
      c1_q     <= '0;
      c2_q     <= '0;
      led1_q   <= 1'b0;
      led2_q   <= 1'b0;
      led3_q   <= 1'b0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      blank_q  <= 1'b0;
      rgb_q    <= 8'h00;
    end else begin
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      led1_q   <= led1_d;
      led2_q   <= led2_d;
      led3_q   <= led3_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      rgb_q    <= rgb_d;
    end
  end

  assign fpga_LEDR0       = fpga_SW0;
  assign fpga_SEL_CLK_AUX = fpga_SW1;
  assign fpga_LEDR1       = led1_q;
  assign fpga_LEDR2       = led2_q;
  assign fpga_LEDR3       = led3_q;

  assign vga_ifm.VGA_CLK   = pix_en_q;
  assign vga_ifm.VGA_HS    = hs_q;
  assign vga_ifm.VGA_VS    = vs_q;
  assign vga_ifm.VGA_BLANK = blank_q;
  assign vga_ifm.VGA_SYNC  = 1'b0;
  assign vga_ifm.VGA_R     = rgb_q;
  assign vga_ifm.VGA_G     = rgb_q;
  assign vga_ifm.VGA_B     = rgb_q;
endmodule

// File: tb/tb_fpga_top.sv
// Scoreboard bench for fpga_top: per-pixel-tick model of sync/blank/RGB, heartbeat
// period checks, random switch pass-through and a mid-frame reset.
module tb_fpga_top;
  localparam int CLK_FREQ = 2000;
  localparam int HDISP    = 160;
  // Fewer visible lines than the reference geometry keeps a full frame short.
  localparam int VDISP    = 20;
  localparam int HFP = 40, HPULSE = 48, HBP = 40;
  localparam int VFP = 13, VPULSE = 3, VBP = 29;
  localparam int HT   = HDISP + HFP + HPULSE + HBP;
  localparam int VT   = VDISP + VFP + VPULSE + VBP;
  localparam int HALF = CLK_FREQ / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw0 = 1'b0;
  logic sw1 = 1'b0;
  logic ledr0, ledr1, ledr2, ledr3, sel_aux;

  vga_if vif();

  fpga_top #(
    .CLK_FREQ(CLK_FREQ), .HDISP(HDISP), .VDISP(VDISP),
    .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .fpga_CLK(clk), .fpga_RST(rst), .fpga_SW0(sw0), .fpga_SW1(sw1),
    .fpga_LEDR0(ledr0), .fpga_LEDR1(ledr1), .fpga_LEDR2(ledr2), .fpga_LEDR3(ledr3),
    .fpga_SEL_CLK_AUX(sel_aux), .vga_ifm(vif)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] tick;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [7:0]  rgb;
  } exp_t;

  exp_t exp_q[$];

  // Expected outputs for the n-th pixel tick since reset, straight from the timing rules.
  function automatic exp_t model(input int n);
    exp_t e;
    int x, y;
    logic vis, white;
    x = n % HT;
    y = (n / HT) % VT;
    vis = (x < HDISP) && (y < VDISP);
`ifdef TEST_PATTERN_EN
    white = ((x % 16) == 0) || ((y % 16) == 0);
`else
    white = 1'b0;
`endif
    e.tick  = n;
    e.hs    = !((x >= HDISP + HFP) && (x < HDISP + HFP + HPULSE));
    e.vs    = !((y >= VDISP + VFP) && (y < VDISP + VFP + VPULSE));
    e.blank = vis;
    e.rgb   = (vis && white) ? 8'hFF : 8'h00;
    return e;
  endfunction

  // Clocks since reset release; the pixel rate is half the clock, so every
  // second edge completes one pixel tick.
  int since = 0;
  always @(posedge clk) begin
    if (rst) begin
      since = 0;
      exp_q.delete();
    end else begin
      since++;
      if (since % 2 == 0) exp_q.push_back(model(since / 2 - 1));
    end
  end

  // Monitor: a new VGA sample is presented when VGA_CLK falls.
  logic prev_vclk = 1'b0;
  int   n_pop = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vclk = 1'b0;
      n_pop = 0;
    end else begin
      if (prev_vclk && !vif.VGA_CLK) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          n_pop++;
          n_cmp++;
          if ({vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK, vif.VGA_SYNC, vif.VGA_R, vif.VGA_G, vif.VGA_B}
              !== {e.hs, e.vs, e.blank, 1'b0, e.rgb, e.rgb, e.rgb}) begin
            n_bad++;
            $display("FAIL vga_tick %0d: got hs=%b vs=%b blank=%b sync=%b rgb=%h/%h/%h, expected hs=%b vs=%b blank=%b sync=0 rgb=%h",
                     e.tick, vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK, vif.VGA_SYNC,
                     vif.VGA_R, vif.VGA_G, vif.VGA_B, e.hs, e.vs, e.blank, e.rgb);
          end
        end
      end
      prev_vclk = vif.VGA_CLK;
    end
  end

  // Heartbeats: first rise HALF clocks after release, then one rise every 2*HALF.
  logic p1 = 1'b0, p2 = 1'b0;
  int   last1 = -1, last2 = -1;
  always @(negedge clk) begin
    if (rst) begin
      p1 = 1'b0; p2 = 1'b0; last1 = -1; last2 = -1;
    end else begin
      if (ledr1 && !p1) begin
        if (last1 < 0) check("ledr1_first_rise", 32'(since), 32'(HALF));
        else           check("ledr1_period", 32'(since - last1), 32'(2 * HALF));
        last1 = since;
      end
      if (ledr2 && !p2) begin
        if (last2 < 0) check("ledr2_first_rise", 32'(since), 32'(HALF));
        else           check("ledr2_period", 32'(since - last2), 32'(2 * HALF));
        last2 = since;
      end
      p1 = ledr1;
      p2 = ledr2;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_ledr1"}, 32'(ledr1), 32'd0);
    check({tag, "_ledr2"}, 32'(ledr2), 32'd0);
    check({tag, "_ledr3"}, 32'(ledr3), 32'd0);
    check({tag, "_vga_clk"}, 32'(vif.VGA_CLK), 32'd0);
    check({tag, "_hs"}, 32'(vif.VGA_HS), 32'd1);
    check({tag, "_vs"}, 32'(vif.VGA_VS), 32'd1);
    check({tag, "_blank"}, 32'(vif.VGA_BLANK), 32'd0);
    check({tag, "_sync"}, 32'(vif.VGA_SYNC), 32'd0);
    check({tag, "_rgb"}, {8'h00, vif.VGA_R, vif.VGA_G, vif.VGA_B}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk);
    #1 check("ledr3_release", 32'(ledr3), 32'd1);

    // Random switch activity while the first frame runs.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sw0 = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      sw1 = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      check("ledr0_pass", 32'(ledr0), 32'(sw0));
      check("sel_aux_pass", 32'(sel_aux), 32'(sw1));
      repeat ($urandom_range(100, 800)) @(posedge clk);
    end
    while (since < 2 * HT * VT + 2000) @(posedge clk);

    // Reset in the middle of a frame and restart from x = y = 0.
    repeat ($urandom_range(1, 3000)) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    @(posedge clk);
    #1 check("ledr3_midrst_release", 32'(ledr3), 32'd1);
    repeat (6000) @(posedge clk);

    @(negedge clk);
    #1;
    check("sb_pop_count", 32'(n_pop), 32'(since / 2));
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
